// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 codes, result_src encodings
// and the LSU handshake state machine encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables and store-data
// replication, load byte/half extraction with sign/zero extension, and
// detection of misaligned or illegal-funct3 accesses.
module lsu_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Byte lane at the offset, and the half selected by offset bit 1.
  assign lane_b = 8'(load_word >> {off, 3'b000});
  assign lane_h = 16'(load_word >> {off[1], 4'b0000});

  // Decode access size into lanes, extended data and fault flags.
  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      F3_BU: begin
        be        = 4'b0001 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'b0, lane_b};
        illegal   = is_store;
      end
      F3_H: begin
        be         = 4'b0011 << off;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{lane_h[15]}}, lane_h};
        misaligned = off[0];
      end
      F3_HU: begin
        be         = 4'b0011 << off;
        wdata      = {2{store_data[15:0]}};
        load_data  = {16'b0, lane_h};
        misaligned = off[0];
        illegal    = is_store;
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_word;
        misaligned = (off != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage. Handshake: o_dmem_req is a request that stays
// asserted (with addr/we/be/wdata stable) until a cycle with
// i_dmem_ready=1, which is the acceptance cycle; a load then waits in
// WAIT_RSP for exactly one i_dmem_rvalid cycle carrying i_dmem_rdata.
// The stage stalls upstream until the access completes and registers
// the MEM/WB values, inserting bubbles while stalled.
module mem_stage_lsu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_reg_write_m,
  input  logic [1:0]      i_result_src_m,
  input  logic            i_mem_write_m,
  input  logic [2:0]      i_funct3_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_write_data_m,
  input  logic [4:0]      i_rd_m,
  input  logic [XLEN-1:0] i_pc_plus4_m,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ready,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall_m,
  output logic            o_lsu_exc,
  output logic            o_reg_write_w,
  output logic [1:0]      o_result_src_w,
  output logic [XLEN-1:0] o_alu_result_w,
  output logic [XLEN-1:0] o_read_data_w,
  output logic [4:0]      o_rd_w,
  output logic [XLEN-1:0] o_pc_plus4_w,
  output lsu_state_e      o_lsu_state
);

  lsu_state_e      state, state_next;
  logic            is_store, is_load, access, bad, legal, complete;
  logic [3:0]      align_be;
  logic [XLEN-1:0] align_wdata, load_data;
  logic            misaligned, illegal;

  // A store wins if both store and load-result are flagged.
  assign is_store = i_mem_write_m;
  assign is_load  = !i_mem_write_m && (i_result_src_m == RS_LOAD);
  assign access   = is_store || is_load;
  assign bad      = access && (misaligned || illegal);
  assign legal    = access && !bad;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (i_funct3_m),
    .off        (i_alu_result_m[1:0]),
    .is_store   (is_store),
    .store_data (i_write_data_m),
    .load_word  (i_dmem_rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // FSM state register; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: grant moves stores home and loads to response wait.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (legal) begin
          if (i_dmem_ready) state_next = is_store ? IDLE : WAIT_RSP;
          else              state_next = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (i_dmem_ready) state_next = is_store ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (i_dmem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs, completion and stall; rvalid only counts in WAIT_RSP.
  always_comb begin
    o_dmem_req = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        o_dmem_req = legal;
        complete   = legal && i_dmem_ready && is_store;
      end
      WAIT_GNT: begin
        o_dmem_req = 1'b1;
        complete   = i_dmem_ready && is_store;
      end
      WAIT_RSP: begin
        complete = i_dmem_rvalid;
      end
      default: begin
        o_dmem_req = 1'b0;
        complete   = 1'b0;
      end
    endcase
    o_stall_m = legal && !complete;
  end

  // Request fields follow the held EX/MEM inputs, so they stay stable.
  assign o_dmem_we    = is_store;
  assign o_dmem_addr  = {i_alu_result_m[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = align_wdata;
  assign o_dmem_be    = align_be;
  assign o_lsu_state  = state;

  // MEM/WB register: bubble while stalled or faulting, else capture.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_reg_write_w  <= 1'b0;
      o_result_src_w <= 2'b00;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_rd_w         <= 5'd0;
      o_pc_plus4_w   <= '0;
    end else if (o_stall_m || bad) begin
      o_reg_write_w <= 1'b0;
    end else begin
      o_reg_write_w  <= i_reg_write_m;
      o_result_src_w <= i_result_src_m;
      o_alu_result_w <= i_alu_result_m;
      o_read_data_w  <= load_data;
      o_rd_w         <= i_rd_m;
      o_pc_plus4_w   <= i_pc_plus4_m;
    end
  end

  // Exception pulse follows the faulting M cycle by one clock.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_lsu_exc <= 1'b0;
    else         o_lsu_exc <= bad;
  end

endmodule
